// File: rtl/stream_rr_arbiter_pkg.sv
// stream_rr_arbiter_pkg: shared stream-utility types
package stream_rr_arbiter_pkg;
  typedef enum logic {IDLE, LOCKED} arb_state_e;
endpackage

// File: rtl/skid_buffer.sv
// skid_buffer: two-entry registered stream stage, full throughput with registered in_ready
module skid_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);
  logic             skid_full;
  logic [WIDTH-1:0] skid_data;
  assign in_ready = ~skid_full;
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      skid_full <= 1'b0;
    end else if (!out_valid || out_ready) begin
      if (skid_full) begin
        out_data  <= skid_data;
        out_valid <= 1'b1;
        skid_full <= 1'b0;
      end else begin
        out_valid <= in_valid;
        if (in_valid) out_data <= in_data;
      end
    end else if (in_valid && in_ready) begin
      skid_data <= in_data;
      skid_full <= 1'b1;
    end
  end
endmodule

// File: rtl/stream_rr_arbiter.sv
// stream_rr_arbiter: packet-locked round-robin merge of NUM_INPUTS streams into one skid-buffered output
module stream_rr_arbiter
  import stream_rr_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_INPUTS = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_INPUTS-1:0]            in_valid,
  input  logic [NUM_INPUTS-1:0]            in_last,
  output logic [NUM_INPUTS-1:0]            in_ready,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic                             out_last,
  output logic [$clog2(NUM_INPUTS)-1:0]    out_src,
  output logic                             out_valid,
  input  logic                             out_ready
);
  localparam int SW = $clog2(NUM_INPUTS);
  localparam int BW = DATA_WIDTH + 1 + SW;
  arb_state_e              state, state_d;
  logic [SW-1:0]           grant, grant_d, last_grant, last_grant_d, start, pick;
  logic [2*NUM_INPUTS-1:0] rot;
  logic [SW:0]             off, sum;
  logic                    locked, accept, sb_in_ready, sb_out_valid;
  logic [BW-1:0]           sb_out;
  // rotate so bit 0 is the requester just after the last grant, then take the lowest set bit
  always_comb begin
    start = (last_grant == SW'(NUM_INPUTS - 1)) ? '0 : last_grant + 1'b1;
    rot   = {in_valid, in_valid} >> start;
    off   = '0;
    for (int i = NUM_INPUTS - 1; i >= 0; i--) if (rot[i]) off = (SW+1)'(i);
    sum  = {1'b0, start} + off;
    pick = (sum >= (SW+1)'(NUM_INPUTS)) ? SW'(sum - (SW+1)'(NUM_INPUTS)) : sum[SW-1:0];
  end
  assign locked = (state == LOCKED) && !reset;
  assign accept = locked && in_valid[grant] && sb_in_ready;
  assign in_ready = (locked && sb_in_ready) ? NUM_INPUTS'(1) << grant : '0;
  always_comb begin
    state_d      = state;
    grant_d      = grant;
    last_grant_d = last_grant;
    if (state == IDLE) begin
      if (|in_valid) begin
        state_d = LOCKED;
        grant_d = pick;
      end
    end else if (accept && in_last[grant]) begin
      state_d      = IDLE;
      last_grant_d = grant;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= SW'(NUM_INPUTS - 1);
    end else begin
      state      <= state_d;
      grant      <= grant_d;
      last_grant <= last_grant_d;
    end
  end
  skid_buffer #(.WIDTH(BW)) u_skid (
    .clk      (clk),
    .reset    (reset),
    .in_data  ({grant, in_last[grant], in_data[grant*DATA_WIDTH +: DATA_WIDTH]}),
    .in_valid (locked && in_valid[grant]),
    .in_ready (sb_in_ready),
    .out_data (sb_out),
    .out_valid(sb_out_valid),
    .out_ready(out_ready)
  );
  assign out_valid = sb_out_valid && !reset;
  assign {out_src, out_last, out_data} = sb_out;
endmodule

// File: tb/tb_stream_rr_arbiter.sv
// tb_stream_rr_arbiter: random and directed stimulus against a packet-level round-robin model with a 2-deep output queue
module tb_stream_rr_arbiter;
  localparam int W = 8;
  localparam int N = 4;
  localparam int SW = 2;
  logic clk = 1'b0;
  logic reset, out_ready, out_last, out_valid;
  logic [N*W-1:0] in_data;
  logic [N-1:0] in_valid, in_last, in_ready;
  logic [W-1:0] out_data;
  logic [SW-1:0] out_src;
  always #5 clk = ~clk;
  stream_rr_arbiter #(.DATA_WIDTH(W), .NUM_INPUTS(N)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .out_data(out_data), .out_last(out_last), .out_src(out_src),
    .out_valid(out_valid), .out_ready(out_ready)
  );
  int errors = 0, checks = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  logic [W:0] src_mem [N][64];
  int src_rd [N], src_wr [N];
  bit en [N];
  bit rnd = 0, ordy = 0;
  int owner = -1, lastg = N - 1;
  logic [W+SW:0] mq [$];
  logic [SW-1:0] dut_log [$];
  task automatic push_beat(input int r, input logic [W:0] b);
    src_mem[r][src_wr[r] % 64] = b;
    src_wr[r]++;
  endtask
  task automatic push_pkt(input int r, input int len);
    for (int k = 0; k < len; k++) push_beat(r, {k == len - 1, W'($urandom)});
  endtask
  task automatic drive();
    logic [W:0] b;
    out_ready = rnd ? ($urandom_range(0, 9) < 7) : ordy;
    for (int r = 0; r < N; r++) begin
      if (rnd && src_rd[r] == src_wr[r] && $urandom_range(0, 3) == 0) push_pkt(r, $urandom_range(1, 4));
      en[r] = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      b = (src_rd[r] != src_wr[r]) ? src_mem[r][src_rd[r] % 64] : '0;
      in_valid[r] = (src_rd[r] != src_wr[r]) && en[r];
      in_last[r] = b[W];
      in_data[r*W +: W] = b[W-1:0];
    end
  endtask
  task automatic step();
    logic [N-1:0] er;
    logic [W:0] b;
    bit acc, pop, found;
    int c;
    @(negedge clk);
    er = '0;
    if (!reset && owner >= 0 && mq.size() < 2) er[owner] = 1'b1;
    check("in_ready", in_ready, er);
    check("out_valid", out_valid, !reset && mq.size() > 0);
    if (!reset && mq.size() > 0) check("out_beat", {out_src, out_last, out_data}, mq[0]);
    if (reset) begin
      owner = -1;
      lastg = N - 1;
      mq.delete();
      for (int r = 0; r < N; r++) src_rd[r] = src_wr[r];
    end else begin
      if (out_valid && out_ready) dut_log.push_back(out_src);
      acc = owner >= 0 && in_valid[owner] && mq.size() < 2;
      pop = mq.size() > 0 && out_ready;
      if (pop) void'(mq.pop_front());
      if (acc) begin
        b = src_mem[owner][src_rd[owner] % 64];
        src_rd[owner]++;
        mq.push_back({SW'(owner), b});
        if (b[W]) begin
          lastg = owner;
          owner = -1;
        end
      end else if (owner < 0) begin
        found = 0;
        for (int i = 1; i <= N; i++) begin
          c = (lastg + i) % N;
          if (!found && in_valid[c]) begin
            owner = c;
            found = 1;
          end
        end
      end
    end
    @(posedge clk);
    #1;
    drive();
  endtask
  task automatic do_reset();
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    dut_log.delete();
  endtask
  initial begin
    logic [SW-1:0] exp36 [5];
    logic [SW-1:0] exp37 [5];
    for (int r = 0; r < N; r++) begin
      src_rd[r] = 0;
      src_wr[r] = 0;
    end
    reset = 1'b1;
    drive();
    do_reset();
    ordy = 1;
    push_beat(2, 9'h011);
    push_beat(2, 9'h022);
    push_beat(2, 9'h133);
    drive();
    repeat (8) step();
    check("s035_count", dut_log.size(), 3);
    foreach (dut_log[k]) check("s035_src", dut_log[k], 2);
    do_reset();
    for (int r = 0; r < N; r++) push_pkt(r, 1);
    push_pkt(0, 1);
    drive();
    repeat (14) step();
    exp36 = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    check("s036_count", dut_log.size(), 5);
    for (int k = 0; k < 5 && k < dut_log.size(); k++) check("s036_order", dut_log[k], exp36[k]);
    do_reset();
    push_pkt(1, 4);
    drive();
    repeat (3) step();
    push_pkt(0, 1);
    drive();
    repeat (12) step();
    exp37 = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd0};
    check("s037_count", dut_log.size(), 5);
    for (int k = 0; k < 5 && k < dut_log.size(); k++) check("s037_order", dut_log[k], exp37[k]);
    do_reset();
    push_pkt(3, 6);
    drive();
    repeat (3) step();
    ordy = 0;
    drive();
    repeat (5) step();
    ordy = 1;
    drive();
    repeat (10) step();
    check("s038_count", dut_log.size(), 6);
    do_reset();
    push_pkt(1, 4);
    drive();
    repeat (3) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    dut_log.delete();
    push_pkt(1, 2);
    push_pkt(0, 1);
    drive();
    repeat (10) step();
    check("s039_count", dut_log.size(), 3);
    if (dut_log.size() > 0) check("s039_first", dut_log[0], 0);
    rnd = 1;
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 199) == 0);
      step();
    end
    reset = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
